input_port_buffer: RTL and testbench
====================================

# input_port_buffer

Synchronous receive buffer between the external 16-bit input port and the writeback source mux. It accepts words from an off-chip producer over a valid/ready handshake and holds them in a small FIFO. It presents the oldest word on `data_in` for the input-port writeback selection (`write_data_src` = 3'b101). It pops that word when the consuming instruction retires, and raises `stall` when such an instruction finds the buffer empty.

## Interface
Parameters:
- `WIDTH`, 16: data word width; must match the writeback mux inputs.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ext_data`  in  WIDTH  word offered by the external producer.
- `ext_valid`  in  1  producer has a word on `ext_data`.
- `ext_ready`  out  1  buffer can accept a word this cycle.
- `rd_req`  in  1  writeback of the current instruction selects input-port data (decoded `write_data_src` == 3'b101, instruction valid).
- `data_in`  out  WIDTH  head-of-FIFO word, driven to the writeback mux.
- `stall`  out  1  `rd_req` with buffer empty; holds the pipeline.
- `empty`  out  1  no words held.
- `count`  out  $clog2(DEPTH+1)  number of words held.

## Operation
- Storage: DEPTH x WIDTH array, read pointer and write pointer each $clog2(DEPTH) bits, and `count`. Pointers wrap modulo DEPTH.
- Push: `ext_valid && ext_ready` at a rising edge writes `ext_data` at the write pointer, then increments the write pointer and `count`.
- `ext_ready` = (`count` != DEPTH). It depends on registered state only, never on `rd_req`. A full buffer refuses a push even in a cycle that pops.
- Pop: `rd_req && !empty` at a rising edge increments the read pointer and decrements `count`. The word consumed is the one shown on `data_in` during that cycle.
- `data_in` = array[read pointer] when `!empty`, otherwise all zeros. It is never X.
- `stall` = `rd_req && empty`, combinational. No pop occurs in that cycle. The pipeline re-presents `rd_req` on following cycles until data arrives.
- Simultaneous push and pop (not full, not empty): both pointers advance and `count` is unchanged.
- Simultaneous push and `rd_req` while empty: the word is written, `stall` is 1 in that cycle, and there is no pop. The word is available to `rd_req` on the next cycle. There is no bypass from `ext_data` to `data_in`.
- `count` never exceeds DEPTH and never goes below 0. By construction neither overflow nor underflow is possible.
- Reset: pointers = 0, `count` = 0. Array contents are not cleared. Resulting outputs: `ext_ready` = 1, `empty` = 1, `data_in` = 0. `stall` = `rd_req`.
- Reset mid-operation: all held words are discarded. A push offered in the reset cycle is not accepted; `ext_ready` is forced to 0 while `rst` = 1.

## Timing
- Push-to-visible latency: 1 cycle. A word accepted at edge N appears on `data_in` after edge N when it is the head.
- Pop latency: 0 cycles to consume. The next word appears on `data_in` immediately after the pop edge.
- Full throughput: one push and one pop per cycle sustained when 0 < `count` < DEPTH.
- `stall`, `data_in` and `ext_ready` are combinational from registered state plus `rd_req`. There is no path from `ext_valid` or `ext_data` to any output.

## Structure
- Shared package `hydra_pkg` holds:
  - `DATA_W` = 16.
  - The `write_data_src` encodings `WDS_ALU`=000, `WDS_MEM`=001, `WDS_DATA_RG`=010, `WDS_MEM_RG`=011, `WDS_IMM`=100, `WDS_DATA_IN`=101. The decoder driving `rd_req` uses these.
- One natural sub-module: `sync_fifo_mem`, the DEPTH x WIDTH register array with one write port and one asynchronous read port. Pointer, count, handshake and stall logic stay in `input_port_buffer`.

## Test plan
- Reset, then idle → `ext_ready`=1, `empty`=1, `count`=0, `data_in`=16'h0000. `rd_req`=1 gives `stall`=1.
- Push 16'hA5A5, 16'h0001, 16'hFFFF on consecutive cycles, then assert `rd_req` for 3 cycles → `data_in` reads A5A5, 0001, FFFF in order. `count` goes 3→2→1→0 and `stall` stays 0.
- Push 4 words (DEPTH=4) → `ext_ready`=0 and `count`=4. Offer a 5th word (16'h1234) with `ext_valid` held, and pop once in the same cycle → the 5th word is not accepted and `count`=3. It is accepted the following cycle and appears as the 4th pop.
- `rd_req`=1 while empty, with a push of 16'hBEEF in the same cycle → `stall`=1 in that cycle. The next cycle gives `data_in`=BEEF, `stall`=0, and a pop.
- Wrap-around: 10 interleaved push/pop pairs with values 1..10 → all read back in order, with pointers wrapping past 3→0.
- Hold 2 words, assert `rst` for 1 cycle with `ext_valid`=1 → afterwards `count`=0 and `empty`=1, and the word offered during reset is not stored.

Source files
------------

// File: rtl/hydra_pkg.sv
// hydra_pkg
//   Shared definitions for the datapath blocks.
//   DATA_W        : datapath word width
//   wds_e         : write_data_src encodings that select the writeback source.
//                   WDS_DATA_IN selects the input-port buffer head word.
package hydra_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        WDS_ALU     = 3'b000,
        WDS_MEM     = 3'b001,
        WDS_DATA_RG = 3'b010,
        WDS_MEM_RG  = 3'b011,
        WDS_IMM     = 3'b100,
        WDS_DATA_IN = 3'b101
    } wds_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
//   DEPTH x WIDTH register array with one synchronous write port and one
//   asynchronous read port. Contents are not reset.
//   clk_i    : system clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : array[raddr_i], combinational
module sync_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/input_port_buffer.sv
// input_port_buffer
//   Receive FIFO between the external input port and the writeback mux.
//   clk        : system clock, all state on rising edge
//   rst        : synchronous active-high reset
//   ext_data   : word offered by the external producer
//   ext_valid  : producer has a word on ext_data
//   ext_ready  : buffer can accept a word this cycle
//   rd_req     : retiring instruction selects input-port data (WDS_DATA_IN)
//   data_in    : head-of-FIFO word, zero when empty
//   stall      : rd_req while empty
//   empty      : no words held
//   count      : number of words held
//
// Handshake: a word transfers on a rising edge where ext_valid && ext_ready
// are both high; ext_ready is a function of registered state (and rst) only,
// so the producer may hold ext_valid/ext_data until it sees the transfer.
module input_port_buffer
    import hydra_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           ext_data,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic                       rd_req,
    output logic [WIDTH-1:0]           data_in,
    output logic                       stall,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [WIDTH-1:0] head_word;

    assign empty     = (count_q == '0);
    // A full buffer refuses a push even when the same cycle pops; this keeps
    // ext_ready independent of rd_req. Held low during reset so nothing is
    // accepted in that cycle.
    assign ext_ready = !rst && (count_q != CW'(DEPTH));
    assign push      = ext_valid && ext_ready;
    assign pop       = rd_req && !empty;
    assign stall     = rd_req && empty;
    assign count     = count_q;

    // Array contents are never cleared, so mask the read when empty.
    assign data_in   = empty ? '0 : head_word;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (ext_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_word)
    );

endmodule

// File: tb/tb_input_port_buffer.sv
module tb_input_port_buffer;

    localparam int W = 16;
    localparam int D = 4;
    localparam int CW = $clog2(D+1);

    logic          clk;
    logic          rst;
    logic [W-1:0]  ext_data;
    logic          ext_valid;
    logic          ext_ready;
    logic          rd_req;
    logic [W-1:0]  data_in;
    logic          stall;
    logic          empty;
    logic [CW-1:0] count;

    int n_checks;
    int n_errors;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          rst;
        logic          valid;
        logic [W-1:0]  data;
        logic          rd;
        logic          e_ready;
        logic          e_empty;
        logic [CW-1:0] e_count;
        logic [W-1:0]  e_din;
        logic          e_stall;
    } vec_t;

    vec_t vq[$];

    input_port_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .rd_req    (rd_req),
        .data_in   (data_in),
        .stall     (stall),
        .empty     (empty),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: inputs change just after the falling edge, outputs sampled 1ns later
    task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic rd);
        @(negedge clk);
        rst       = r;
        ext_valid = v;
        ext_data  = d;
        rd_req    = rd;
        #1;
    endtask

    task automatic add_vec(input logic r, input logic v, input logic [W-1:0] d, input logic rd,
                           input logic e_ready, input logic e_empty, input logic [CW-1:0] e_count,
                           input logic [W-1:0] e_din, input logic e_stall);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.rd = rd;
        t.e_ready = e_ready; t.e_empty = e_empty; t.e_count = e_count;
        t.e_din = e_din; t.e_stall = e_stall;
        vq.push_back(t);
    endtask

    task automatic check_all(input string tag, input vec_t t);
        check({tag, ".ext_ready"}, 32'(ext_ready), 32'(t.e_ready));
        check({tag, ".empty"},     32'(empty),     32'(t.e_empty));
        check({tag, ".count"},     32'(count),     32'(t.e_count));
        check({tag, ".data_in"},   32'(data_in),   32'(t.e_din));
        check({tag, ".stall"},     32'(stall),     32'(t.e_stall));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        ext_valid = 1'b0;
        ext_data  = '0;
        rd_req    = 1'b0;

        //        rst v  data      rd  rdy emp cnt din       stall
        // reset, idle, stall on empty
        add_vec(0, 0, 16'h0000, 0,  1,  1,  0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  1,  0, 16'h0000, 1);
        // three pushes then three pops in order
        add_vec(0, 1, 16'hA5A5, 0,  1,  1,  0, 16'h0000, 0);
        add_vec(0, 1, 16'h0001, 0,  1,  0,  1, 16'hA5A5, 0);
        add_vec(0, 1, 16'hFFFF, 0,  1,  0,  2, 16'hA5A5, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  3, 16'hA5A5, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  2, 16'h0001, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  1, 16'hFFFF, 0);
        add_vec(0, 0, 16'h0000, 0,  1,  1,  0, 16'h0000, 0);
        // fill to DEPTH, 5th word refused while full even with a pop
        add_vec(0, 1, 16'h0011, 0,  1,  1,  0, 16'h0000, 0);
        add_vec(0, 1, 16'h0022, 0,  1,  0,  1, 16'h0011, 0);
        add_vec(0, 1, 16'h0033, 0,  1,  0,  2, 16'h0011, 0);
        add_vec(0, 1, 16'h0044, 0,  1,  0,  3, 16'h0011, 0);
        add_vec(0, 1, 16'h1234, 1,  0,  0,  4, 16'h0011, 0);
        add_vec(0, 1, 16'h1234, 0,  1,  0,  3, 16'h0022, 0);
        add_vec(0, 0, 16'h0000, 1,  0,  0,  4, 16'h0022, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  3, 16'h0033, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  2, 16'h0044, 0);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  1, 16'h1234, 0);
        // rd_req on empty with simultaneous push: stall, no bypass
        add_vec(0, 1, 16'hBEEF, 1,  1,  1,  0, 16'h0000, 1);
        add_vec(0, 0, 16'h0000, 1,  1,  0,  1, 16'hBEEF, 0);
        add_vec(0, 0, 16'h0000, 0,  1,  1,  0, 16'h0000, 0);

        // reset cycles: nothing accepted
        drive(1, 1, 16'hDEAD, 0);
        check("rst.ext_ready", 32'(ext_ready), 32'd0);
        drive(1, 0, 16'h0000, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].valid, vq[i].data, vq[i].rd);
            check_all($sformatf("vec%0d", i), vq[i]);
        end

        // wrap-around: push 1, then push k / pop together, then drain
        drive(0, 1, 16'd1, 0);
        check("wrap.first.count", 32'(count), 32'd0);
        exp_q.push_back(16'd1);
        for (int k = 2; k <= 10; k++) begin
            drive(0, 1, W'(k), 1);
            check($sformatf("wrap%0d.count", k), 32'(count), 32'd1);
            check($sformatf("wrap%0d.ready", k), 32'(ext_ready), 32'd1);
            check($sformatf("wrap%0d.data_in", k), 32'(data_in), 32'(exp_q.pop_front()));
            exp_q.push_back(W'(k));
        end
        drive(0, 0, 16'h0000, 1);
        check("wrap.last.data_in", 32'(data_in), 32'(exp_q.pop_front()));
        check("wrap.last.stall", 32'(stall), 32'd0);
        drive(0, 0, 16'h0000, 0);
        check("wrap.drained.empty", 32'(empty), 32'd1);

        // reset mid-operation discards held words and the offered word
        drive(0, 1, 16'h5555, 0);
        drive(0, 1, 16'h6666, 0);
        check("midrst.pre.count", 32'(count), 32'd1);
        drive(1, 1, 16'h7777, 0);
        check("midrst.ready", 32'(ext_ready), 32'd0);
        check("midrst.held", 32'(count), 32'd2);
        drive(0, 0, 16'h0000, 0);
        check("midrst.count", 32'(count), 32'd0);
        check("midrst.empty", 32'(empty), 32'd1);
        check("midrst.ext_ready", 32'(ext_ready), 32'd1);
        check("midrst.data_in", 32'(data_in), 32'd0);
        drive(0, 0, 16'h0000, 1);
        check("midrst.stall", 32'(stall), 32'd1);
        check("midrst.count2", 32'(count), 32'd0);
        drive(0, 0, 16'h0000, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // absolute time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
